alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue stage for the 4-function combinational ALU mux (div/add/sub/mul, 16-bit Y).
//  Accepts one {opcode, A, B} request per valid/ready handshake and decodes the opcode to the mux select.
//  Drives the mux operands from registers and captures Y into a held result with an output valid/ready handshake.
//  Traps illegal opcodes and divide-by-zero, so the mux never divides by 0.
// PARAMETERS
//  DATA_W  8  operand width; fixed to the mux operand width
//  OPC_W   4  opcode width
//  CNT_W   8  error-counter width; used only with ALU_ERRCNT_EN
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       reset, synchronous, active-low
//  in_valid        in   1       request valid
//  in_ready        out  1       request accepted when in_valid & in_ready
//  in_opcode       in   OPC_W   0001 div, 0010 add, 0011 sub, 0100 mul; all others illegal
//  in_a            in   DATA_W  operand A
//  in_b            in   DATA_W  operand B
//  mux_a           out  DATA_W  to ALU mux A
//  mux_b           out  DATA_W  to ALU mux B
//  mux_sel         out  2       to ALU mux P: 00 div, 01 add, 10 sub, 11 mul
//  mux_enable_low  out  1       to ALU mux enable_low; 0 = compute, 1 = mux drives 0
//  mux_y           in   2*DATA_W  from ALU mux Y
//  out_valid       out  1       result valid; held until out_ready
//  out_ready       in   1       consumer ready
//  out_result      out  2*DATA_W  captured result
//  out_err         out  1       1 = illegal opcode or divide-by-zero
//  err_count       out  CNT_W   saturating error count; present only with ALU_ERRCNT_EN
// BEHAVIOUR
//  FSM states: IDLE, EXEC, DONE; reset state IDLE.
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; mux_a=mux_b=0; mux_sel=00; mux_enable_low=1.
//   - out_valid=0; out_result=0; out_err=0; err_count=0.
//   - in_ready=0 while rst_n=0.
//  in_ready = (state==IDLE) & rst_n.
//  IDLE, on accept:
//   - Legal op, not div-by-0: register A/B to mux_a/mux_b, decoded opcode to mux_sel; mux_enable_low<=0; go EXEC.
//   - Illegal opcode: out_result<=16'h0000, out_err<=1; go DONE; mux untouched (enable_low stays 1).
//   - Opcode 0001 with in_b==0: out_result<=16'hFFFF, out_err<=1; go DONE; mux untouched.
//  EXEC, exactly 1 cycle:
//   - out_result<=mux_y, out_err<=0; mux_enable_low<=1; go DONE.
//  DONE:
//   - out_valid=1 with out_result/out_err stable until out_ready=1, then go IDLE.
//   - No same-cycle accept in DONE; next request accepted in IDLE.
//  Latency and throughput:
//   - Accept at edge k -> out_valid=1 after edge k+2 (legal ops) or k+1 (trapped).
//   - Max rate: 1 op per 3 cycles.
//  Outside EXEC, mux_a/mux_b/mux_sel hold their last values; mux_enable_low=1.
//  Arithmetic is performed by the mux; mux_y passes through unmodified:
//   - add: zero-extended 9-bit sum.
//   - sub: mod 2^16 (3-5 -> 16'hFFFE).
//   - mul: full 16-bit product.
//   - div: zero-extended quotient.
//  Reset mid-operation (EXEC or DONE): op abandoned, no out_valid; new requests accepted the cycle after reset release.
//  out_ready=1 while not in DONE: ignored.
// CONFIGURATION
//  ALU_ERRCNT_EN defined:
//   - err_count increments by 1 on each accepted trapped request (illegal or div-by-0).
//   - Saturates at 2^CNT_W-1; cleared only by reset.
//  ALU_ERRCNT_EN undefined: err_count port and counter logic absent; all other behaviour identical.
// TESTING
//  add: op 0010, A=200, B=100 -> out_valid after 2 edges, out_result=16'd300, out_err=0; mux_sel=01 during EXEC.
//  mul with backpressure: op 0100, A=255, B=255, out_ready=0 for 5 cycles
//    -> out_result=16'hFE01 held stable with out_valid=1; in_ready=0 until drained.
//  div-by-zero: op 0001, A=9, B=0 -> mux_enable_low never 0, out_result=16'hFFFF, out_err=1;
//    err_count 0->1 with macro.
//  illegal/sub: op 0111 -> out_result=0, out_err=1; then op 0011, A=3, B=5 -> out_result=16'hFFFE, out_err=0.
//  reset in EXEC: accept op 0010, assert rst_n=0 next cycle -> no out_valid, mux_enable_low=1,
//    in_ready=1 the cycle after release.
//  saturation (macro, CNT_W=2): 5 illegal ops -> err_count=3.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue stage for the div/add/sub/mul ALU mux: handshake in, trap, drive mux, hold result.
// Optional saturating trap counter on err_count when ALU_ERRCNT_EN is defined.
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]   mux_a,
  output logic [DATA_W-1:0]   mux_b,
  output logic [1:0]          mux_sel,
  output logic                mux_enable_low,
  input  logic [2*DATA_W-1:0] mux_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_result,
  output logic                out_err
`ifdef ALU_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]    err_count
`endif
);

  localparam int RES_W = 2 * DATA_W;

  localparam logic [OPC_W-1:0] OpDiv = OPC_W'(1);
  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(2);
  localparam logic [OPC_W-1:0] OpSub = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpMul = OPC_W'(4);

  if (DATA_W < 1 || OPC_W < 3 || CNT_W < 1) begin : g_bad_param
    $error("alu_op_sequencer: bad width parameter");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mux_a_q, mux_a_d;
  logic [DATA_W-1:0]  mux_b_q, mux_b_d;
  logic [1:0]         mux_sel_q, mux_sel_d;
  logic               en_low_q, en_low_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic               out_err_q, out_err_d;

  logic       op_legal;
  logic [1:0] op_sel;
  logic       div_zero;

  always_comb begin
    op_legal = 1'b1;
    op_sel   = 2'b00;
    case (in_opcode)
      OpDiv:   op_sel = 2'b00;
      OpAdd:   op_sel = 2'b01;
      OpSub:   op_sel = 2'b10;
      OpMul:   op_sel = 2'b11;
      default: op_legal = 1'b0;
    endcase
  end

  assign div_zero = (in_opcode == OpDiv) && (in_b == '0);
  assign in_ready = (state_q == IDLE) && rst_n;

  always_comb begin
    state_d      = state_q;
    mux_a_d      = mux_a_q;
    mux_b_d      = mux_b_q;
    mux_sel_d    = mux_sel_q;
    en_low_d     = 1'b1;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!op_legal) begin
            out_result_d = '0;
            out_err_d    = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else if (div_zero) begin
            out_result_d = '1;
            out_err_d    = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            mux_a_d   = in_a;
            mux_b_d   = in_b;
            mux_sel_d = op_sel;
            en_low_d  = 1'b0;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        out_result_d = mux_y;
        out_err_d    = 1'b0;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mux_a_q      <= '0;
      mux_b_q      <= '0;
      mux_sel_q    <= 2'b00;
      en_low_q     <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mux_a_q      <= mux_a_d;
      mux_b_q      <= mux_b_d;
      mux_sel_q    <= mux_sel_d;
      en_low_q     <= en_low_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

  assign mux_a          = mux_a_q;
  assign mux_b          = mux_b_q;
  assign mux_sel        = mux_sel_q;
  assign mux_enable_low = en_low_q;
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_err        = out_err_q;

`ifdef ALU_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             trap;

  assign trap = (state_q == IDLE) && in_valid && (!op_legal || div_zero);

  // Saturate rather than wrap so a flood of bad ops stays visible.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (trap && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
